pr_timer: RTL and testbench

Programmable down-counting timer on the processor bus, the responder end of the CPU's PrAddr/PrWD/PrWE/PrRD path and a source of its HWInt lines. It is selected by the system bridge for a 16-byte window and holds three word registers: CTRL, PRESET and COUNT. It counts PRESET down to zero and raises an interrupt in one-shot or auto-reload mode. Its IRQ output drives HWInt[2].

---
 rtl/pr_timer_pkg.sv | 13 +
 rtl/pr_timer.sv | 67 ++++++
 tb/tb_pr_timer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pr_timer_pkg.sv
// pr_timer_pkg: shared types and constants for the pr_timer bus timer
package pr_timer_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} timerState;
  localparam logic [1:0] CTRL = 2'd0;
  localparam logic [1:0] PRESET = 2'd1;
  localparam logic [1:0] COUNT = 2'd2;
  localparam int CTRL_EN = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM = 3;
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD = 2'b01;
endpackage

// File: rtl/pr_timer.sv
// pr_timer: programmable down-counting timer with one-shot/auto-reload interrupt
module pr_timer
  import pr_timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Sel,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        IRQ
);
  logic [3:0] ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic pending;
  timerState state;
  logic writeCtrl;
  logic writePreset;
  logic reload;
  logic setPend;
  logic clrPend;
  assign writeCtrl = Sel & WE & (Addr == CTRL);
  assign writePreset = Sel & WE & (Addr == PRESET);
  assign reload = ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD;
  assign setPend = (state == CNT) & ctrl[CTRL_EN] & (count <= 32'd1);
  assign clrPend = ((state == INT) & reload) | (~reload & (writeCtrl | writePreset));
  assign IRQ = ctrl[CTRL_IM] & pending;
  // registers, count FSM and pending flag; CPU CTRL writes override the one-shot Enable clear
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl <= '0;
      preset <= '0;
      count <= '0;
      pending <= 1'b0;
      state <= IDLE;
    end else begin
      if (writeCtrl) ctrl <= DIn[3:0];
      else if (state == INT && !reload) ctrl[CTRL_EN] <= 1'b0;
      if (writePreset) preset <= DIn;
      pending <= setPend | (pending & ~clrPend);
      case (state)
        IDLE: if (ctrl[CTRL_EN]) state <= LOAD;
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!ctrl[CTRL_EN]) state <= IDLE;
          else if (count > 32'd1) count <= count - 32'd1;
          else begin
            count <= '0;
            state <= INT;
          end
        end
        INT: state <= reload ? LOAD : IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // read mux: combinational on Addr, reserved offset reads zero
  always_comb
    DOut = (Addr == CTRL) ? {28'b0, ctrl} :
           (Addr == PRESET) ? preset :
           (Addr == COUNT) ? count : 32'b0;
endmodule

// File: tb/tb_pr_timer.sv
// tb_pr_timer: randomized self-checking bench for pr_timer using closed-form timing expectations
module tb_pr_timer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic Sel = 1'b0;
  logic WE = 1'b0;
  logic [1:0] Addr = 2'd0;
  logic [31:0] DIn = 32'd0;
  logic [31:0] DOut;
  logic IRQ;
  int checks = 0;
  int errors = 0;

  pr_timer dut (.clk(clk), .reset(reset), .Sel(Sel), .Addr(Addr), .WE(WE), .DIn(DIn), .DOut(DOut), .IRQ(IRQ));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    Addr = a;
    #1;
    v = DOut;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    Sel = 1'b1;
    WE = 1'b1;
    Addr = a;
    DIn = d;
    @(posedge clk);
    #1;
    Sel = 1'b0;
    WE = 1'b0;
    DIn = $urandom;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    doReset();
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], v);
      checks++;
      if (v !== 32'd0) begin errors++; $display("FAIL reset_read addr=%0d got=%h exp=0", a, v); end
    end
    checks++;
    if (IRQ !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", IRQ); end
  endtask

  task automatic test_oneshot(input int n, input logic im, input logic [1:0] mode);
    logic [31:0] v;
    logic [31:0] expCount;
    logic [31:0] expCtrl;
    doReset();
    wr(1, n);
    wr(0, {$urandom_range(0, 32'h0FFF_FFFF), im, mode, 1'b1});
    for (int j = 1; j <= n + 5; j++) begin
      step();
      if (j >= 2) begin
        expCount = (j - 2 < n) ? n - (j - 2) : 0;
        rd(2, v);
        checks++;
        if (v !== expCount) begin errors++; $display("FAIL oneshot_count n=%0d j=%0d got=%0d exp=%0d", n, j, v, expCount); end
      end
      checks++;
      if (IRQ !== (im && j >= n + 2)) begin errors++; $display("FAIL oneshot_irq n=%0d j=%0d got=%b exp=%b", n, j, IRQ, im && j >= n + 2); end
      expCtrl = {28'b0, im, mode, j < n + 3};
      rd(0, v);
      checks++;
      if (v !== expCtrl) begin errors++; $display("FAIL oneshot_ctrl n=%0d j=%0d got=%h exp=%h", n, j, v, expCtrl); end
    end
    wr(0, {28'b0, im, 3'b000});
    checks++;
    if (IRQ !== 1'b0) begin errors++; $display("FAIL oneshot_clear_irq got=%b exp=0", IRQ); end
    rd(2, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("FAIL oneshot_idle_count got=%0d exp=0", v); end
  endtask

  task automatic test_reload(input int n);
    logic [31:0] v;
    logic [31:0] expCount;
    logic expIrq;
    int p;
    doReset();
    wr(1, n);
    wr(0, 32'hABCD_EF0B);
    for (int j = 1; j <= (n + 2) * 4 + 2; j++) begin
      step();
      expIrq = (j >= n + 2) && ((j - n - 2) % (n + 2) == 0);
      checks++;
      if (IRQ !== expIrq) begin errors++; $display("FAIL reload_irq n=%0d j=%0d got=%b exp=%b", n, j, IRQ, expIrq); end
      if (j >= 2) begin
        p = (j - 2) % (n + 2);
        expCount = (p < n) ? n - p : 0;
        rd(2, v);
        checks++;
        if (v !== expCount) begin errors++; $display("FAIL reload_count n=%0d j=%0d got=%0d exp=%0d", n, j, v, expCount); end
      end
    end
    rd(0, v);
    checks++;
    if (v !== 32'hB) begin errors++; $display("FAIL reload_ctrl got=%h exp=b", v); end
  endtask

  task automatic test_midcount(input int n, input int k, input logic [31:0] m);
    logic [31:0] v;
    doReset();
    wr(1, n);
    wr(0, 1);
    repeat (k + 1) @(posedge clk);
    wr(0, 0);
    for (int j = 0; j < 4; j++) begin
      if (j > 0) step();
      rd(2, v);
      checks++;
      if (v !== n - k) begin errors++; $display("FAIL mid_frozen j=%0d got=%0d exp=%0d", j, v, n - k); end
    end
    wr(0, 1);
    step();
    rd(2, v);
    checks++;
    if (v !== n - k) begin errors++; $display("FAIL mid_before_reload got=%0d exp=%0d", v, n - k); end
    step();
    rd(2, v);
    checks++;
    if (v !== n) begin errors++; $display("FAIL mid_reload got=%0d exp=%0d", v, n); end
    wr(1, m);
    rd(2, v);
    checks++;
    if (v !== n - 1) begin errors++; $display("FAIL mid_preset_nodisturb got=%0d exp=%0d", v, n - 1); end
    step();
    wr(0, 0);
    wr(0, 1);
    step();
    step();
    rd(2, v);
    checks++;
    if (v !== m) begin errors++; $display("FAIL mid_new_preset got=%0d exp=%0d", v, m); end
  endtask

  task automatic test_preset_zero(input logic im);
    logic [31:0] v;
    doReset();
    wr(1, 0);
    wr(0, {28'b0, im, 3'b001});
    for (int j = 1; j <= 4; j++) begin
      step();
      rd(0, v);
      checks++;
      if (v[0] !== (j < 4)) begin errors++; $display("FAIL zero_enable im=%b j=%0d got=%b exp=%b", im, j, v[0], j < 4); end
      checks++;
      if (IRQ !== (im && j >= 3)) begin errors++; $display("FAIL zero_irq im=%b j=%0d got=%b exp=%b", im, j, IRQ, im && j >= 3); end
    end
    wr(0, 8);
    checks++;
    if (IRQ !== 1'b0) begin errors++; $display("FAIL zero_clear_irq im=%b got=%b exp=0", im, IRQ); end
    rd(0, v);
    checks++;
    if (v !== 32'h8) begin errors++; $display("FAIL zero_ctrl got=%h exp=8", v); end
  endtask

  task automatic test_collisions(input int n);
    logic [31:0] v;
    doReset();
    wr(1, n);
    wr(0, 1);
    repeat (n + 2) @(posedge clk);
    wr(0, 9);
    rd(0, v);
    checks++;
    if (v !== 32'h9) begin errors++; $display("FAIL col_cpu_wins got=%h exp=9", v); end
    checks++;
    if (IRQ !== 1'b0) begin errors++; $display("FAIL col_cpu_irq got=%b exp=0", IRQ); end
    step();
    step();
    rd(2, v);
    checks++;
    if (v !== n) begin errors++; $display("FAIL col_restart_count got=%0d exp=%0d", v, n); end
    doReset();
    wr(1, n);
    wr(0, 9);
    repeat (n + 1) @(posedge clk);
    wr(1, n);
    checks++;
    if (IRQ !== 1'b1) begin errors++; $display("FAIL col_set_wins got=%b exp=1", IRQ); end
    wr(1, n);
    checks++;
    if (IRQ !== 1'b0) begin errors++; $display("FAIL col_preset_clears got=%b exp=0", IRQ); end
    doReset();
    wr(1, n);
    wr(0, 3);
    repeat (n + 1) @(posedge clk);
    wr(0, 32'hB);
    checks++;
    if (IRQ !== 1'b1) begin errors++; $display("FAIL col_reload_im_raise got=%b exp=1", IRQ); end
    step();
    checks++;
    if (IRQ !== 1'b0) begin errors++; $display("FAIL col_reload_pulse got=%b exp=0", IRQ); end
  endtask

  task automatic test_count_write_reset(input int n);
    logic [31:0] v;
    doReset();
    wr(1, n);
    wr(0, 9);
    repeat (2) @(posedge clk);
    wr(2, 32'hFFFF_FFFF);
    rd(2, v);
    checks++;
    if (v !== n - 1) begin errors++; $display("FAIL count_ro got=%0d exp=%0d", v, n - 1); end
    step();
    doReset();
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], v);
      checks++;
      if (v !== 32'd0) begin errors++; $display("FAIL midreset_read addr=%0d got=%h exp=0", a, v); end
    end
    wr(1, 1);
    wr(0, 9);
    repeat (3) step();
    checks++;
    if (IRQ !== 1'b1) begin errors++; $display("FAIL pend_before_reset got=%b exp=1", IRQ); end
    doReset();
    checks++;
    if (IRQ !== 1'b0) begin errors++; $display("FAIL pend_after_reset got=%b exp=0", IRQ); end
    wr(0, 8);
    checks++;
    if (IRQ !== 1'b0) begin errors++; $display("FAIL pend_lost got=%b exp=0", IRQ); end
  endtask

  initial begin
    logic [1:0] osModes [3];
    osModes[0] = 2'b00;
    osModes[1] = 2'b10;
    osModes[2] = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_oneshot(5, 1'b1, 2'b00);
    for (int i = 0; i < 4; i++)
      test_oneshot($urandom_range(1, 12), 1'($urandom_range(0, 1)), osModes[$urandom_range(0, 2)]);
    test_reload(3);
    for (int i = 0; i < 3; i++) test_reload($urandom_range(1, 6));
    test_midcount(10, 3, 32'd6);
    for (int i = 0; i < 3; i++) begin
      int n;
      n = $urandom_range(5, 20);
      test_midcount(n, $urandom_range(1, n - 2), $urandom_range(1, 50));
    end
    test_preset_zero(1'b0);
    test_preset_zero(1'b1);
    for (int i = 0; i < 3; i++) test_collisions($urandom_range(1, 5));
    test_count_write_reset($urandom_range(10, 30));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
